inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 13, instruction-memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, instruction word width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; all ports are listed below, one per line.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a load session
- base_addr  in  ADDR_WIDTH  first write address of the session
- req_valid  in  1  encode request present
- req_ready  out  1  encoder accepts a request this cycle
- req_sel  in  4  instruction kind, same code as the decoder's sel output
- req_imm  in  14  literal immediate
- req_funct  in  4  ALU function code, maps to word[12:9]
- req_esl  in  2  ALU select, maps to word[8:7]
- req_target  in  ADDR_WIDTH  branch/call/L target
- req_last  in  1  this request ends the session
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_WIDTH  write address
- mem_wdata  out  DATA_WIDTH  encoded instruction word
- busy  out  1  session in progress
- done  out  1  one-cycle pulse, session finished
- err  out  1  sticky: illegal req_sel seen this session
- wrap  out  1  sticky: address wrapped this session
- word_count  out  ADDR_WIDTH+1  words written this session

Function
REQ-004 The FSM SHALL have states IDLE, ACCEPT, WRITE, FINISH.
REQ-005 IDLE: start=1 SHALL load mem_addr<=base_addr, clear err, wrap and word_count, and go to ACCEPT; start is ignored in every other state.
REQ-006 req_ready SHALL be 1 only in ACCEPT; a request is taken when req_valid and req_ready are both 1 in the same cycle.
REQ-007 On acceptance the block SHALL register the encoded word and go to WRITE; with req_valid=0 it SHALL stay in ACCEPT indefinitely.
REQ-008 WRITE SHALL assert mem_we for exactly one cycle with mem_wdata and mem_addr stable, so the write lands the cycle after acceptance; the maximum rate is one word per 2 cycles.
REQ-009 After the write strobe, mem_addr SHALL increment by 1 and word_count by 1; 2^ADDR_WIDTH-1 SHALL wrap to 0 and set wrap.
REQ-010 The block SHALL go from WRITE to FINISH when the accepted request had req_last=1, otherwise to ACCEPT.
REQ-011 FINISH SHALL pulse done for one cycle and return to IDLE; busy SHALL be 1 in ACCEPT, WRITE and FINISH.
REQ-012 Encoding SHALL use the shared `INST_TYPE_* opcode macros in word[15:13]:
- sel 0001 literal: word = {2'b11, req_imm}.
- sel 0000 NOP: word = 16'h0000.
- sel 0010 ALU: {INST_TYPE_CTRL, req_funct, req_esl, 7'b0}.
- sel 0011 STA: {INST_TYPE_STA, 13'b0}.
- sel 0100 L: {INST_TYPE_L, 1'b0, req_target[11:0]}.
- sel 0101/0110/0111: {INST_TYPE_J / INST_TYPE_CJ / INST_TYPE_CALL, req_target[12:0]}.
REQ-013 An ALU request whose encoding would equal 16'h0000 SHALL force word[0]=1 so that it never decodes as a NOP.
REQ-014 req_sel values 1000-1111 SHALL be consumed without a write (no mem_we, no address or count change) and SHALL set err; a req_last on such a request still ends the session.

Reset
REQ-015 rst_n=0 SHALL asynchronously force state IDLE, req_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, wrap=0, word_count=0; a reset during a session aborts it with no further write.

Configuration
REQ-016 With ENC_CHECKSUM_EN defined, the block SHALL add an output checksum [DATA_WIDTH-1:0] that is cleared at start and updated to checksum+mem_wdata (mod 2^16) on every mem_we, and is 0 after reset; without the macro, the port and its logic SHALL be absent.

Verification
REQ-017 start, base=0x0010; literal imm=0x1234, last=1 -> one mem_we at addr 0x0010, wdata 0xD234, then done; word_count=1.
REQ-018 Three back-to-back requests with req_valid held high -> mem_we at addresses base, base+1, base+2, in cycles N+1, N+3, N+5.
REQ-019 base=0x1FFF, two NOP requests -> writes at 0x1FFF then 0x0000, wdata 0x0000, wrap=1.
REQ-020 Request with sel=1010, then an L request with target 0xABC and last=1 -> err=1, a single write of {INST_TYPE_L,1'b0,12'hABC} at base.
REQ-021 rst_n low during WRITE -> mem_we is low immediately and all outputs are 0; a new start afterwards works normally.
REQ-022 With ENC_CHECKSUM_EN: writes 0xD234 and 0x0001 -> checksum=0xD235.

Source files
------------

// File: rtl/inst_encoder.sv
// Instruction encoder: turns a stream of encode requests into words written to instruction memory. Optional checksum output when ENC_CHECKSUM_EN is defined.
// Latency: the write strobe fires the cycle after acceptance; throughput is at most one word per 2 cycles.
// Backpressure: req_ready is high only while waiting for a request; req_valid may stay low indefinitely.

`ifndef INST_TYPE_CTRL
`define INST_TYPE_CTRL 3'b000
`endif
`ifndef INST_TYPE_STA
`define INST_TYPE_STA  3'b001
`endif
`ifndef INST_TYPE_L
`define INST_TYPE_L    3'b010
`endif
`ifndef INST_TYPE_J
`define INST_TYPE_J    3'b011
`endif
`ifndef INST_TYPE_CJ
`define INST_TYPE_CJ   3'b100
`endif
`ifndef INST_TYPE_CALL
`define INST_TYPE_CALL 3'b101
`endif

module inst_encoder #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_sel,
    input  logic [13:0]           req_imm,
    input  logic [3:0]            req_funct,
    input  logic [1:0]            req_esl,
    input  logic [ADDR_WIDTH-1:0] req_target,
    input  logic                  req_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  wrap,
    output logic [ADDR_WIDTH:0]   word_count
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t        state;
    logic          last_q;
    logic [15:0]   enc_word;
    logic          sel_legal;

    // Combinational encoder for the request currently presented.
    always_comb begin
        enc_word  = 16'h0000;
        sel_legal = 1'b1;
        case (req_sel)
            4'b0000: enc_word = 16'h0000;
            4'b0001: enc_word = {2'b11, req_imm};
            4'b0010: begin
                enc_word = {`INST_TYPE_CTRL, req_funct, req_esl, 7'b0};
                // An all-zero ALU word would be indistinguishable from NOP.
                if (enc_word == 16'h0000)
                    enc_word[0] = 1'b1;
            end
            4'b0011: enc_word = {`INST_TYPE_STA, 13'b0};
            4'b0100: enc_word = {`INST_TYPE_L, 1'b0, req_target[11:0]};
            4'b0101: enc_word = {`INST_TYPE_J, req_target[12:0]};
            4'b0110: enc_word = {`INST_TYPE_CJ, req_target[12:0]};
            4'b0111: enc_word = {`INST_TYPE_CALL, req_target[12:0]};
            default: sel_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_q     <= 1'b0;
            req_ready  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            wrap       <= 1'b0;
            word_count <= '0;
`ifdef ENC_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr   <= base_addr;
                        err        <= 1'b0;
                        wrap       <= 1'b0;
                        word_count <= '0;
`ifdef ENC_CHECKSUM_EN
                        checksum   <= '0;
`endif
                        req_ready  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        last_q    <= req_last;
                        state     <= WRITE;
                        // Illegal kinds still pass through WRITE, just without a strobe.
                        if (sel_legal) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= DATA_WIDTH'(enc_word);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        mem_addr   <= mem_addr + 1'b1;
                        word_count <= word_count + 1'b1;
                        if (&mem_addr)
                            wrap <= 1'b1;
`ifdef ENC_CHECKSUM_EN
                        checksum <= checksum + mem_wdata;
`endif
                    end
                    if (last_q) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        req_ready <= 1'b1;
                        state     <= ACCEPT;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [12:0] base_addr;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_sel;
    logic [13:0] req_imm;
    logic [3:0]  req_funct;
    logic [1:0]  req_esl;
    logic [12:0] req_target;
    logic        req_last;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        wrap;
    logic [13:0] word_count;
`ifdef ENC_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    inst_encoder #(.ADDR_WIDTH(13), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .req_imm    (req_imm),
        .req_funct  (req_funct),
        .req_esl    (req_esl),
        .req_target (req_target),
        .req_last   (req_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wrap       (wrap),
        .word_count (word_count)
`ifdef ENC_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] sel, input logic [13:0] imm, input logic [3:0] funct,
                           input logic [1:0] esl, input logic [12:0] tgt, input logic last);
        req_valid  = 1'b1;
        req_sel    = sel;
        req_imm    = imm;
        req_funct  = funct;
        req_esl    = esl;
        req_target = tgt;
        req_last   = last;
    endtask

    task automatic begin_session(input logic [12:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_we"},    32'(mem_we),    32'h0);
        chk({tag, "_addr"},  32'(mem_addr),  32'h0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
        chk({tag, "_busy"},  32'(busy),      32'h0);
        chk({tag, "_done"},  32'(done),      32'h0);
        chk({tag, "_err"},   32'(err),       32'h0);
        chk({tag, "_wrap"},  32'(wrap),      32'h0);
        chk({tag, "_cnt"},   32'(word_count), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; req_valid = 1'b0;
        req_sel = '0; req_imm = '0; req_funct = '0; req_esl = '0; req_target = '0; req_last = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single literal session.
        begin_session(13'h0010);
        chk("lit_ready", 32'(req_ready), 32'h1);
        chk("lit_busy",  32'(busy),      32'h1);
        chk("lit_base",  32'(mem_addr),  32'h0010);
        set_req(4'b0001, 14'h1234, 4'h0, 2'b00, 13'h0, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("lit_we",    32'(mem_we),    32'h1);
        chk("lit_addr",  32'(mem_addr),  32'h0010);
        chk("lit_wdata", 32'(mem_wdata), 32'hD234);
        chk("lit_rdy_w", 32'(req_ready), 32'h0);
        tick();
        chk("lit_we_off", 32'(mem_we),    32'h0);
        chk("lit_done",   32'(done),      32'h1);
        chk("lit_cnt",    32'(word_count), 32'h1);
        chk("lit_addr_n", 32'(mem_addr),  32'h0011);
        tick();
        chk("lit_done_off", 32'(done), 32'h0);
        chk("lit_idle",     32'(busy), 32'h0);

        // Back-to-back ALU, STA, J with valid held high.
        begin_session(13'h0100);
        set_req(4'b0010, 14'h0, 4'h5, 2'b10, 13'h0, 1'b0);
        tick();
        chk("b2b_we0",    32'(mem_we),    32'h1);
        chk("b2b_addr0",  32'(mem_addr),  32'h0100);
        chk("b2b_data0",  32'(mem_wdata), 32'h0B00);
        set_req(4'b0011, 14'h0, 4'h0, 2'b00, 13'h0, 1'b0);
        tick();
        chk("b2b_gap0",   32'(mem_we),    32'h0);
        chk("b2b_rdy1",   32'(req_ready), 32'h1);
        tick();
        chk("b2b_we1",    32'(mem_we),    32'h1);
        chk("b2b_addr1",  32'(mem_addr),  32'h0101);
        chk("b2b_data1",  32'(mem_wdata), 32'h2000);
        set_req(4'b0101, 14'h0, 4'h0, 2'b00, 13'h1ABC, 1'b1);
        tick();
        chk("b2b_gap1",   32'(mem_we),    32'h0);
        tick();
        req_valid = 1'b0;
        chk("b2b_we2",    32'(mem_we),    32'h1);
        chk("b2b_addr2",  32'(mem_addr),  32'h0102);
        chk("b2b_data2",  32'(mem_wdata), 32'h7ABC);
        tick();
        chk("b2b_done",   32'(done),      32'h1);
        chk("b2b_cnt",    32'(word_count), 32'h3);
        tick();

        // Address wrap with two NOPs.
        begin_session(13'h1FFF);
        set_req(4'b0000, 14'h0, 4'h0, 2'b00, 13'h0, 1'b0);
        tick();
        req_valid = 1'b0;
        chk("wrap_addr0", 32'(mem_addr),  32'h1FFF);
        chk("wrap_data0", 32'(mem_wdata), 32'h0000);
        chk("wrap_we0",   32'(mem_we),    32'h1);
        tick();
        chk("wrap_flag",  32'(wrap),      32'h1);
        chk("wrap_addr1", 32'(mem_addr),  32'h0000);
        set_req(4'b0000, 14'h0, 4'h0, 2'b00, 13'h0, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("wrap_we1",   32'(mem_we),    32'h1);
        chk("wrap_addr2", 32'(mem_addr),  32'h0000);
        tick();
        chk("wrap_cnt",   32'(word_count), 32'h2);
        chk("wrap_keep",  32'(wrap),      32'h1);
        tick();

        // Illegal sel is consumed silently, then an L request.
        begin_session(13'h0020);
        chk("err_clear", 32'(wrap), 32'h0);
        set_req(4'b1010, 14'h3FFF, 4'hF, 2'b11, 13'h1FFF, 1'b0);
        tick();
        req_valid = 1'b0;
        chk("ill_we",   32'(mem_we), 32'h0);
        chk("ill_err",  32'(err),    32'h1);
        tick();
        chk("ill_addr", 32'(mem_addr),  32'h0020);
        chk("ill_cnt",  32'(word_count), 32'h0);
        set_req(4'b0100, 14'h0, 4'h0, 2'b00, 13'h0ABC, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("l_we",    32'(mem_we),    32'h1);
        chk("l_addr",  32'(mem_addr),  32'h0020);
        chk("l_wdata", 32'(mem_wdata), 32'h4ABC);
        tick();
        chk("l_done",  32'(done),      32'h1);
        chk("l_cnt",   32'(word_count), 32'h1);
        chk("l_err",   32'(err),       32'h1);
        tick();

        // Illegal request carrying last still ends the session.
        begin_session(13'h0030);
        set_req(4'b1111, 14'h0, 4'h0, 2'b00, 13'h0, 1'b1);
        tick();
        req_valid = 1'b0;
        tick();
        chk("ill_last_done", 32'(done),      32'h1);
        chk("ill_last_cnt",  32'(word_count), 32'h0);
        tick();

        // Reset asserted while the write strobe is high.
        begin_session(13'h0040);
        set_req(4'b0001, 14'h0055, 4'h0, 2'b00, 13'h0, 1'b0);
        tick();
        req_valid = 1'b0;
        chk("rst_pre_we", 32'(mem_we), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_after_we", 32'(mem_we), 32'h0);

        // Fresh session after reset: literal then all-zero ALU.
        begin_session(13'h0050);
        chk("post_ready", 32'(req_ready), 32'h1);
        set_req(4'b0001, 14'h1234, 4'h0, 2'b00, 13'h0, 1'b0);
        tick();
        chk("post_wdata0", 32'(mem_wdata), 32'hD234);
        chk("post_addr0",  32'(mem_addr),  32'h0050);
        set_req(4'b0010, 14'h0, 4'h0, 2'b00, 13'h0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("alu0_wdata", 32'(mem_wdata), 32'h0001);
        chk("alu0_addr",  32'(mem_addr),  32'h0051);
        tick();
        chk("post_cnt",   32'(word_count), 32'h2);
`ifdef ENC_CHECKSUM_EN
        chk("checksum",   32'(checksum),  32'hD235);
`endif
        tick();
        chk("post_idle",  32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
